// File: rtl/aula_201029_key_pkg.sv
// ============================================================================
// Module  : aula_201029_key_pkg
// Brief   : Shared defaults and helpers for the key debounce block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aula_201029_key_pkg;

   localparam int NUM_KEYS_DEFAULT        = 4;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

   // Smallest width whose range strictly exceeds the terminal count.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

   function automatic logic idle_level(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/aula_201029_key_debounce_ch.sv
// ============================================================================
// Module  : aula_201029_key_debounce_ch
// Brief   : One key channel: 2-flop synchroniser, debounce counter, stable
//           register and registered press/release pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aula_201029_key_debounce_ch
   import aula_201029_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES),
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key,
   output logic o_clean,
   output logic o_press,
   output logic o_release
);

   localparam logic             c_idle_lvl  = idle_level(KEY_ACTIVE_LOW != 0);
   localparam logic             c_press_lvl = ~c_idle_lvl;
   localparam logic [CNT_W-1:0] c_cnt_term  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             r_release;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= c_idle_lvl;
         r_sync2   <= c_idle_lvl;
         r_stable  <= c_idle_lvl;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync1   <= i_key;
         r_sync2   <= r_sync1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         // A single cycle of agreement restarts the qualification window.
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_term) begin
            r_stable  <= r_sync2;
            r_cnt     <= '0;
            r_press   <= (r_sync2 == c_press_lvl);
            r_release <= (r_sync2 != c_press_lvl);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_clean   = r_stable;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

`default_nettype wire

// File: rtl/aula_201029_key_debounce.sv
// ============================================================================
// Module  : aula_201029_key_debounce
// Brief   : Synchronises and debounces NUM_KEYS raw push-buttons for the key
//           PIO, with per-channel press/release pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aula_201029_key_debounce
   import aula_201029_key_pkg::*;
#(
   parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 20,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_clean,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   // The counter must reach DEBOUNCE_CYCLES-1 without wrapping.
   generate
      if ((DEBOUNCE_CYCLES < 1) || ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_param_check
         $error("aula_201029_key_debounce: need DEBOUNCE_CYCLES >= 1 and 2**CNT_W > DEBOUNCE_CYCLES");
      end
   endgenerate

   generate
      for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
         aula_201029_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
         ) u_ch (
            .clk       (clk),
            .rst       (reset),
            .i_key     (key_in[i]),
            .o_clean   (key_clean[i]),
            .o_press   (key_press[i]),
            .o_release (key_release[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: doc/aula_201029_key_debounce.md
Name: aula_201029_key_debounce

Overview:
Conditioning stage directly upstream of the key PIO. It takes the four raw, asynchronous, bouncing push-button inputs from the board and synchronises each one to clk. It debounces each channel with a per-channel counter. Outputs:
- key_clean: a glitch-free level that drives the PIO in_port; board polarity is kept, so software reads are unchanged.
- key_press / key_release: single-cycle pulses for future interrupt or edge-capture logic.

Parameters:
NUM_KEYS, 4, number of independent key channels.
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a new level must persist before it is accepted (20 ms at 50 MHz). Must be >= 1.
CNT_W, 20, debounce counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES; elaboration error otherwise.
KEY_ACTIVE_LOW, 1, 1 = a pressed key drives 0 (board default), 0 = a pressed key drives 1.

Ports:
clk  input  1  system clock, sole clock domain.
reset  input  1  asynchronous, active-high reset.
key_in  input  NUM_KEYS  raw key pins, asynchronous to clk.
key_clean  output  NUM_KEYS  debounced level in board polarity; connects to the PIO in_port.
key_press  output  NUM_KEYS  one-cycle pulse per channel when the debounced state enters "pressed".
key_release  output  NUM_KEYS  one-cycle pulse per channel when the debounced state enters "released".

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - Sync flops, stable register and key_clean = IDLE, where IDLE = all-ones if KEY_ACTIVE_LOW else all-zeros.
  - All counters = 0; key_press = key_release = 0.
  - No press or release pulse is produced as a result of reset.
- Synchroniser: two-flop chain per channel, sync2 <= sync1 <= key_in. Nothing else samples key_in.
- Debounce, per channel, evaluated every clk:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - Any single cycle of agreement with stable restarts the qualification window (bounce rejection).
  - The counter never wraps: it is cleared at the terminal value, and the width check guarantees it never overflows.
- key_clean = stable, driven directly from the register with no combinational path from key_in.
- Pulses are registered and assert in the same cycle key_clean changes, for exactly one cycle:
  - key_press when the new stable value is the pressed level.
  - key_release when the new stable value is the released level.
  - key_press and key_release are never both high on the same channel.
- Latency: a clean step on key_in at edge 0 appears in sync2 after 2 edges and on key_clean after 2 + DEBOUNCE_CYCLES edges.
- DEBOUNCE_CYCLES = 1: the block degenerates to the synchroniser plus one register stage; any level differing for one cycle is accepted.
- Channels are fully independent. Simultaneous changes on several keys produce simultaneous pulses on each.
- Reset mid-qualification: the partial count is discarded and key_clean returns to IDLE immediately. After reset release, a key held down is accepted after the full 2 + DEBOUNCE_CYCLES, followed by a press pulse.
- Input toggling faster than DEBOUNCE_CYCLES (continuous bounce): key_clean holds its previous value indefinitely and no pulses are produced.

Decomposition:
- Shared package aula_201029_key_pkg holds:
  - NUM_KEYS_DEFAULT
  - DEBOUNCE_CYCLES_DEFAULT
  - the CNT_W derivation helper (clog2-based)
  - the IDLE level function of KEY_ACTIVE_LOW
- One natural sub-module, aula_201029_key_debounce_ch: a single channel containing synchroniser, counter, stable register and pulse generation. The top generates NUM_KEYS instances and concatenates their outputs.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES = 8 and CNT_W = 4 unless stated.
1. Reset with key_in = 4'hF held -> key_clean = 4'hF, press/release = 0 during and after reset; no pulses for 50 cycles.
2. key_in[0] steps 1->0 cleanly at edge 0 -> key_clean = 4'hE first visible at edge 10; key_press = 4'h1 for exactly that cycle; key_release stays 0.
3. key_in[1] bounces 1->0->1->0 with gaps of 3 cycles, then holds 0 -> key_clean[1] changes only 10 edges after the final transition; exactly one key_press[1] pulse.
4. key_in = 4'h0 simultaneously (all pressed), held 20 cycles, then 4'hF -> key_clean 4'h0 with key_press = 4'hF on one cycle; later key_clean 4'hF with key_release = 4'hF on one cycle.
5. key_in[2] low for 5 cycles then returned high (sub-threshold) -> key_clean stays 4'hF and no pulses. Then reset is asserted after 6 of 8 qualifying cycles on key_in[3] -> key_clean = 4'hF immediately; the full 10-edge latency is required after release.
6. DEBOUNCE_CYCLES = 1, key_in[0] single-cycle low glitch -> key_clean[0] low for one cycle at edge 3, a press pulse then a release pulse; confirms the degenerate case.
